// File: rtl/siso_bank_sched.sv
// siso_bank_sched: round-robin owner of a shared WIDTH-bit SISO chain; sequences
// WIDTH shift cycles per grant, then holds the word for the reader until acked.
module siso_bank_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic            CLK,
    input  logic            RESET_B,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] din,
    output logic [NREQ-1:0] gnt,
    output logic            shift_en,
    output logic            sdi,
    output logic [OW-1:0]   owner,
    output logic            rd_valid,
    input  logic            rd_ack,
    output logic            abort
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            shift_en_q, shift_en_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic            abort_q, abort_d;
    logic            found;
    logic [OW-1:0]   win;
    int              idx;

    // Rotating priority: first set request at or after ptr, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        shift_en_d = shift_en_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        abort_d    = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                state_d    = SHIFT;
                owner_d    = win;
                gnt_d      = NREQ'(1) << win;
                shift_en_d = 1'b1;
                cnt_d      = '0;
                ptr_d      = OW'((int'(win) + 1) % NREQ);
            end
            SHIFT: begin
                // A dropped owner request cancels the word even on the final shift cycle
                if (!req[owner_q]) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    shift_en_d = 1'b0;
                    abort_d    = 1'b1;
                    cnt_d      = '0;
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = HOLD;
                    gnt_d      = '0;
                    shift_en_d = 1'b0;
                    rd_valid_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: if (rd_ack) begin
                state_d    = IDLE;
                rd_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            shift_en_q <= 1'b0;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            shift_en_q <= shift_en_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            abort_q    <= abort_d;
        end
    end

    assign gnt      = gnt_q;
    assign shift_en = shift_en_q;
    assign owner    = owner_q;
    assign rd_valid = rd_valid_q;
    assign abort    = abort_q;
    assign sdi      = din[owner_q] & shift_en_q;
endmodule

// File: tb/tb_siso_bank_sched.sv
// tb_siso_bank_sched: directed scenarios for the shared SISO chain scheduler
// with hand-derived expectations (NREQ=4, WIDTH=8).
module tb_siso_bank_sched;
    logic       CLK = 1'b0;
    logic       RESET_B = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] din = '0;
    logic       rd_ack = 1'b0;
    logic [3:0] gnt;
    logic       shift_en;
    logic       sdi;
    logic [1:0] owner;
    logic       rd_valid;
    logic       abort;
    int         checks = 0;
    int         failures = 0;

    siso_bank_sched #(.NREQ(4), .WIDTH(8)) dut (
        .CLK(CLK), .RESET_B(RESET_B), .req(req), .din(din), .gnt(gnt),
        .shift_en(shift_en), .sdi(sdi), .owner(owner), .rd_valid(rd_valid),
        .rd_ack(rd_ack), .abort(abort)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RESET_B = 1'b0;
        req = '0;
        din = '0;
        rd_ack = 1'b0;
        tick();
        tick();
        RESET_B = 1'b1;
    endtask

    task automatic test_reset;
        RESET_B = 1'b0;
        tick();
        checks++;
        if ({gnt, shift_en, sdi, owner, rd_valid, abort} !== 10'b0) begin
            failures++;
            $display("FAIL reset_values: got gnt=%b se=%b sdi=%b owner=%0d rv=%b ab=%b, want all 0",
                     gnt, shift_en, sdi, owner, rd_valid, abort);
        end
        RESET_B = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0) begin
            failures++;
            $display("FAIL idle_no_req: gnt=%b want 0000", gnt);
        end
    endtask

    task automatic test_single;
        logic [7:0] pat = 8'b10110010;
        req = 4'b0100;
        tick();
        for (int i = 0; i < 8; i++) begin
            din = {1'b0, pat[7-i], 2'b00};
            #1;
            checks++;
            if (gnt !== 4'b0100 || shift_en !== 1'b1 || owner !== 2'd2 || rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_shift[%0d]: gnt=%b se=%b owner=%0d rv=%b want 0100 1 2 0",
                         i, gnt, shift_en, owner, rd_valid);
            end
            checks++;
            if (sdi !== pat[7-i]) begin
                failures++;
                $display("FAIL single_sdi[%0d]: sdi=%b want %b", i, sdi, pat[7-i]);
            end
            tick();
        end
        din = 4'b0100;
        #1;
        checks++;
        if (rd_valid !== 1'b1 || gnt !== 4'b0 || shift_en !== 1'b0 || sdi !== 1'b0 || owner !== 2'd2) begin
            failures++;
            $display("FAIL single_hold: rv=%b gnt=%b se=%b sdi=%b owner=%0d want 1 0000 0 0 2",
                     rd_valid, gnt, shift_en, sdi, owner);
        end
        rd_ack = 1'b1;
        req = '0;
        din = '0;
        tick();
        rd_ack = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || abort !== 1'b0) begin
            failures++;
            $display("FAIL single_ack: rv=%b ab=%b want 0 0", rd_valid, abort);
        end
        tick();
        checks++;
        if (gnt !== 4'b0) begin
            failures++;
            $display("FAIL single_idle: gnt=%b want 0000", gnt);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt;
        logic       exp_rv;
        int         ph;
        do_reset();
        req = 4'b1111;
        rd_ack = 1'b1;
        for (int cyc = 1; cyc <= 48; cyc++) begin
            tick();
            ph = (cyc - 1) % 10;
            exp_gnt = (ph < 8) ? (4'b0001 << (((cyc - 1) / 10) % 4)) : 4'b0000;
            exp_rv = (ph == 8);
            checks++;
            if (gnt !== exp_gnt || shift_en !== (|exp_gnt) || rd_valid !== exp_rv) begin
                failures++;
                $display("FAIL rr_cycle[%0d]: gnt=%b se=%b rv=%b want %b %b %b",
                         cyc, gnt, shift_en, rd_valid, exp_gnt, |exp_gnt, exp_rv);
            end
        end
        req = '0;
        rd_ack = 1'b0;
    endtask

    task automatic test_wrap;
        logic [3:0] reqs [3] = '{4'b1000, 4'b1001, 4'b1001};
        logic [1:0] exp_own [3] = '{2'd3, 2'd0, 2'd3};
        do_reset();
        rd_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req = reqs[k];
            tick();
            checks++;
            if (owner !== exp_own[k] || gnt !== (4'b0001 << exp_own[k])) begin
                failures++;
                $display("FAIL wrap_grant[%0d]: owner=%0d gnt=%b want owner %0d", k, owner, gnt, exp_own[k]);
            end
            repeat (8) tick();
            checks++;
            if (rd_valid !== 1'b1 || owner !== exp_own[k]) begin
                failures++;
                $display("FAIL wrap_done[%0d]: rv=%b owner=%0d want 1 %0d", k, rd_valid, owner, exp_own[k]);
            end
            tick();
        end
        req = '0;
        rd_ack = 1'b0;
    endtask

    task automatic test_abort;
        do_reset();
        req = 4'b0110;
        tick();
        checks++;
        if (owner !== 2'd1 || gnt !== 4'b0010) begin
            failures++;
            $display("FAIL abort_grant: owner=%0d gnt=%b want 1 0010", owner, gnt);
        end
        tick();
        tick();
        req = 4'b0100;
        tick();
        checks++;
        if (abort !== 1'b1 || rd_valid !== 1'b0 || gnt !== 4'b0 || shift_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_pulse: ab=%b rv=%b gnt=%b se=%b want 1 0 0000 0", abort, rd_valid, gnt, shift_en);
        end
        tick();
        checks++;
        if (abort !== 1'b0 || gnt !== 4'b0100 || owner !== 2'd2) begin
            failures++;
            $display("FAIL abort_next: ab=%b gnt=%b owner=%0d want 0 0100 2", abort, gnt, owner);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_back_pressure;
        do_reset();
        req = 4'b1111;
        repeat (9) tick();
        checks++;
        if (rd_valid !== 1'b1 || owner !== 2'd0) begin
            failures++;
            $display("FAIL bp_valid: rv=%b owner=%0d want 1 0", rd_valid, owner);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || shift_en !== 1'b0 || gnt !== 4'b0 || abort !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: rv=%b se=%b gnt=%b ab=%b want 1 0 0000 0",
                         i, rd_valid, shift_en, gnt, abort);
            end
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: rv=%b want 0", rd_valid);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            failures++;
            $display("FAIL bp_next: gnt=%b owner=%0d want 0010 1", gnt, owner);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        tick();
        #2;
        RESET_B = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0 || shift_en !== 1'b0 || rd_valid !== 1'b0 || owner !== 2'd0 || abort !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: gnt=%b se=%b rv=%b owner=%0d ab=%b want all 0",
                     gnt, shift_en, rd_valid, owner, abort);
        end
        req = '0;
        tick();
        RESET_B = 1'b1;
        tick();
        checks++;
        if (abort !== 1'b0 || gnt !== 4'b0) begin
            failures++;
            $display("FAIL async_reset_after: ab=%b gnt=%b want 0 0000", abort, gnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_abort();
        test_back_pressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
